product_reducer: RTL and testbench

Consumes the per-lane products emitted by the SpMV multiply stage and reduces them into one signed integer dot-product per matrix row. Each beat carries up to PARALLELISM products plus a lane mask and a row-end flag. Completed row sums are tagged with a row index and buffered in a small FIFO behind a valid/ready output. The multiply stage cannot be stalled, so this block never backpressures its input. It flags, but does not prevent, result loss.

---
 rtl/product_reducer_pkg.sv | 23 ++
 rtl/product_reducer_sync_fifo.sv | 58 +++++
 rtl/product_reducer.sv | 125 ++++++++++++
 tb/tb_product_reducer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/product_reducer_pkg.sv
// Shared types and elaboration-time width checks for the product reducer.
package product_reducer_pkg;

  localparam int unsigned RED_ACC_WIDTH = 72;
  localparam int unsigned RED_ROW_WIDTH = 16;

  // Accumulator must hold the worst-case lane sum of one beat without wrapping.
  function automatic bit acc_width_ok(input int unsigned acc_w, input int unsigned in_w,
                                      input int unsigned lanes);
    return acc_w >= in_w + $clog2(lanes);
  endfunction

  // FIFO pointers wrap naturally only for power-of-two depths.
  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  typedef struct packed {
    logic signed [RED_ACC_WIDTH-1:0] sum;
    logic [RED_ROW_WIDTH-1:0]        row;
  } row_result_t;

endpackage

// File: rtl/product_reducer_sync_fifo.sv
// Synchronous FIFO with registered head, async active-high reset and occupancy outputs.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     rd_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_wr, do_rd;

  // A write into a full FIFO is accepted when the head is popped in the same cycle.
  always_comb begin
    do_rd = rd_i && (count_q != '0);
    do_wr = wr_i && ((count_q != FullCount) || do_rd);
  end

  // Storage, pointers and occupancy; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (!do_wr && do_rd) count_q <= count_q - 1'b1;
    end
  end

  // Head is read straight from storage; there is no write-to-read bypass.
  always_comb begin
    rdata_o = mem_q[rd_ptr_q];
    full_o  = (count_q == FullCount);
    empty_o = (count_q == '0);
    count_o = count_q;
  end

endmodule

// File: rtl/product_reducer.sv
// Reduces masked per-lane products into one signed sum per row and queues tagged results.
module product_reducer
  import product_reducer_pkg::*;
#(
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned IN_WIDTH    = 64,
  parameter int unsigned ACC_WIDTH   = RED_ACC_WIDTH,
  parameter int unsigned ROW_WIDTH   = RED_ROW_WIDTH,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  in_data [PARALLELISM],
  input  logic [PARALLELISM-1:0]      in_mask,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic [ROW_WIDTH-1:0]        out_row,
  output logic                        overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  // Two beats can still be in flight when in_ready drops.
  localparam logic [CW-1:0] ReadyMax = CW'(FIFO_DEPTH - 3);

  if (!acc_width_ok(ACC_WIDTH, IN_WIDTH, PARALLELISM)) begin : g_bad_acc
    $error("product_reducer: ACC_WIDTH too narrow for IN_WIDTH and PARALLELISM");
  end
  if (!fifo_depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("product_reducer: FIFO_DEPTH must be a power of two and at least 4");
  end
  // The queued record is the fixed-width package struct.
  if (ACC_WIDTH != RED_ACC_WIDTH || ROW_WIDTH != RED_ROW_WIDTH) begin : g_bad_rec
    $error("product_reducer: ACC_WIDTH/ROW_WIDTH must match row_result_t");
  end

  logic signed [ACC_WIDTH-1:0] lane_sum;
  logic signed [ACC_WIDTH-1:0] s1_sum_q;
  logic                        s1_valid_q, s1_last_q;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_next;
  logic [ROW_WIDTH-1:0]        row_cnt_q;
  logic                        overflow_q;
  logic                        push, pop, drop;
  logic                        fifo_full, fifo_empty;
  logic [CW-1:0]               fifo_count;
  row_result_t                 push_rec, head_rec;

  // Adder tree over masked lanes; size cast sign-extends each product.
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      if (in_mask[i]) lane_sum = lane_sum + ACC_WIDTH'(in_data[i]);
    end
  end

  // Stage 1: register the beat sum; bubbles leave the held sum untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sum_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= in_valid;
      s1_last_q  <= in_valid && in_last;
      if (in_valid) s1_sum_q <= lane_sum;
    end
  end

  // Push/pop/drop decisions for the result queue.
  always_comb begin
    acc_next     = acc_q + s1_sum_q;
    push         = s1_valid_q && s1_last_q;
    pop          = out_valid && out_ready;
    drop         = push && fifo_full && !pop;
    push_rec.sum = acc_next;
    push_rec.row = row_cnt_q;
  end

  // Stage 2: accumulate, close rows, and record any dropped result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q      <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_q     <= '0;
          row_cnt_q <= row_cnt_q + 1'b1;
        end else begin
          acc_q <= acc_next;
        end
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(row_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .wr_i    (push),
    .wdata_i (push_rec),
    .rd_i    (pop),
    .rdata_o (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Output view of the queue head and status.
  always_comb begin
    out_valid = !fifo_empty;
    out_data  = head_rec.sum;
    out_row   = head_rec.row;
    in_ready  = (fifo_count <= ReadyMax);
    overflow  = overflow_q;
  end

endmodule

// File: tb/tb_product_reducer.sv
// Directed self-checking bench for product_reducer.
module tb_product_reducer;

  localparam int P  = 4;
  localparam int IW = 64;
  localparam int AW = 72;
  localparam int RW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [IW-1:0] in_data [P];
  logic [P-1:0]         in_mask;
  logic                 in_last;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic [RW-1:0]        out_row;
  logic                 overflow;

  int total = 0;
  int bad   = 0;

  product_reducer #(
    .PARALLELISM (P),
    .IN_WIDTH    (IW),
    .ACC_WIDTH   (AW),
    .ROW_WIDTH   (RW),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive idle inputs with garbage mask/last to confirm bubbles are ignored.
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_mask  = '1;
    in_last  = 1'b1;
    for (int i = 0; i < P; i++) in_data[i] = 64'sd99;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic beat(input logic signed [IW-1:0] d0, input logic signed [IW-1:0] d1,
                      input logic signed [IW-1:0] d2, input logic signed [IW-1:0] d3,
                      input logic [P-1:0] m, input logic l);
    in_valid   = 1'b1;
    in_data[0] = d0;
    in_data[1] = d1;
    in_data[2] = d2;
    in_data[3] = d3;
    in_mask    = m;
    in_last    = l;
    @(posedge clk);
    #1 idle_inputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Check the head, then pop it with a one-cycle out_ready pulse.
  task automatic pop_check(input string tag, input logic [AW-1:0] exp_data,
                           input logic [AW-1:0] exp_row);
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".row"}, out_row, exp_row);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    idle_inputs();
    #12;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_data", out_data, 0);
    check("rst.out_row", out_row, 0);
    check("rst.overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single row, two-cycle latency.
    beat(1, 2, 3, 4, 4'b1111, 1'b1);
    check("single.lat1", out_valid, 0);
    cycles(1);
    pop_check("single", 10, 0);
    check("single.empty", out_valid, 0);
    // out_ready while empty has no effect.
    out_ready = 1'b1;
    cycles(2);
    out_ready = 1'b0;
    check("single.empty_rdy", out_valid, 0);

    // Multi-beat masked row with bubbles in between.
    do_reset();
    beat(5, 5, 5, 5, 4'b0011, 1'b0);
    cycles(2);
    check("multi.no_early", out_valid, 0);
    beat(-3, 7, 0, 0, 4'b0001, 1'b1);
    beat(1, 0, 0, 0, 4'b0001, 1'b1);
    cycles(2);
    pop_check("multi.r0", 7, 0);
    pop_check("multi.r1", 1, 1);
    check("multi.empty", out_valid, 0);

    // Most negative product plus -1, then an empty row.
    do_reset();
    beat(64'sh8000_0000_0000_0000, -1, 0, 0, 4'b0011, 1'b1);
    beat(5, 6, 7, 8, 4'b0000, 1'b1);
    cycles(2);
    pop_check("neg", 72'hFF_7FFF_FFFF_FFFF_FFFF, 0);
    pop_check("emptyrow", 0, 1);

    // Overflow: ten rows into an eight-entry queue with no consumer.
    do_reset();
    for (int k = 0; k < 10; k++) beat(k + 1, 0, 0, 0, 4'b0001, 1'b1);
    cycles(2);
    check("ovf.flag", overflow, 1);
    check("ovf.in_ready", in_ready, 0);
    for (int k = 0; k < 8; k++) pop_check($sformatf("ovf.r%0d", k), k + 1, k);
    check("ovf.drained", out_valid, 0);
    check("ovf.sticky", overflow, 1);
    beat(42, 0, 0, 0, 4'b0001, 1'b1);
    cycles(1);
    pop_check("ovf.next", 42, 10);

    // Full queue with a pop on the same edge as a push: nothing lost.
    do_reset();
    for (int k = 0; k < 8; k++) beat(k + 1, 0, 0, 0, 4'b0001, 1'b1);
    check("fullpop.in_ready", in_ready, 0);
    beat(9, 0, 0, 0, 4'b0001, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("fullpop.overflow", overflow, 0);
    for (int k = 1; k < 9; k++) pop_check($sformatf("fullpop.r%0d", k), k + 1, k);
    check("fullpop.drained", out_valid, 0);
    check("fullpop.overflow2", overflow, 0);

    // Reset mid-row discards the partial sum and restarts row numbering.
    do_reset();
    beat(1, 0, 0, 0, 4'b0001, 1'b1);
    beat(100, 0, 0, 0, 4'b0001, 1'b0);
    cycles(1);
    rst = 1'b1;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.overflow", overflow, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    beat(1, 1, 1, 1, 4'b1111, 1'b1);
    cycles(1);
    pop_check("midrst.row", 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
